// File: rtl/async_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo_if
//  Description : Producer/consumer handshake bundle for the async_fifo buffer.
//                The master side is the producer/consumer datapath; the slave
//                side is the FIFO itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface async_fifo_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  has_data;

    // Datapath side: issues requests and observes status and read data.
    modport master (
        output wr_en,
        output wr_data,
        output rd_en,
        input  full,
        input  rd_data,
        input  empty,
        input  has_data
    );

    // FIFO side: accepts requests and reports status and read data.
    modport slave (
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output full,
        output rd_data,
        output empty,
        output has_data
    );

endinterface
`default_nettype wire

// File: rtl/async_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo
//  Description : Single-clock FIFO, DATA_WIDTH x 2^ADDR_WIDTH, registered read
//                data, exact status flags and a programmable full reserve.
//                The historical name is retained for existing instantiations.
//                Optional build macro ASYNC_FIFO_ASSERT_EN enables simulation
//                assertions on dropped requests and occupancy overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module async_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RESERVE    = 0
) (
    input  wire          clk,
    input  wire          rst_n,
    async_fifo_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_DEPTH       = 1 << ADDR_WIDTH;
    // Occupancy at which the writer is stopped, reserve already subtracted.
    localparam logic [ADDR_WIDTH:0] c_FULL_LEVEL  = (ADDR_WIDTH + 1)'(c_DEPTH - RESERVE);
    localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT   = (ADDR_WIDTH + 1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_PTR_ONE     = (ADDR_WIDTH + 1)'(1);
    // Number of cycles both sides stay busy once reset is released.
    localparam logic [1:0]          c_BUSY_CYCLES = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [c_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [c_DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q,   wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q,   rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
    logic [1:0]            busy_cnt_q, busy_cnt_d;
    logic                  wr_rst_q,   wr_rst_d;
    logic                  rd_rst_q,   rd_rst_d;

    // Reset-busy indications, kept visible under their architectural names.
    logic                  wr_rst;
    logic                  rd_rst;

    // ------------------------------------------------------------------------
    // Combinational status
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic [ADDR_WIDTH-1:0] w_rd_idx;

    assign wr_rst   = wr_rst_q;
    assign rd_rst   = rd_rst_q;

    // Pointers carry one extra wrap bit, so the modular difference is the
    // exact occupancy and full/empty are never ambiguous.
    assign w_count  = wr_ptr_q - rd_ptr_q;
    assign w_empty  = (w_count == '0);
    assign w_full   = (w_count >= c_FULL_LEVEL) || wr_rst_q;

    assign w_wr_idx = wr_ptr_q[ADDR_WIDTH-1:0];
    assign w_rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];

    // Requests against a blocking flag are dropped without touching state.
    assign w_wr_accept = bus.wr_en && !w_full  && !wr_rst_q;
    assign w_rd_accept = bus.rd_en && !w_empty && !rd_rst_q;

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.has_data = !w_empty;
    assign bus.rd_data  = rd_data_q;

    // ------------------------------------------------------------------------
    // Reset-busy sequencing
    // ------------------------------------------------------------------------

    // Count down the post-reset busy window; both sides release together.
    always_comb begin : busy_next
        busy_cnt_d = busy_cnt_q;
        wr_rst_d   = (busy_cnt_q != 2'd0);
        rd_rst_d   = (busy_cnt_q != 2'd0);
        if (busy_cnt_q != 2'd0) begin
            busy_cnt_d = busy_cnt_q - 2'd1;
        end
    end

    // Busy registers: forced busy while reset is held.
    always_ff @(posedge clk) begin : busy_regs
        if (!rst_n) begin
            busy_cnt_q <= c_BUSY_CYCLES;
            wr_rst_q   <= 1'b1;
            rd_rst_q   <= 1'b1;
        end else begin
            busy_cnt_q <= busy_cnt_d;
            wr_rst_q   <= wr_rst_d;
            rd_rst_q   <= rd_rst_d;
        end
    end

    // ------------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------------

    // Advance the write pointer on every accepted write.
    always_comb begin : wr_ptr_next
        wr_ptr_d = wr_ptr_q;
        if (w_wr_accept) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
    end

    // Place an accepted word in the slot addressed by the write pointer.
    always_comb begin : mem_next
        mem_d = mem_q;
        if (w_wr_accept) begin
            mem_d[w_wr_idx] = bus.wr_data;
        end
    end

    // Storage array; contents are invalidated by pointer reset, not cleared.
    always_ff @(posedge clk) begin : mem_regs
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------------

    // Advance the read pointer and load the output word on an accepted read;
    // otherwise the output word is held.
    always_comb begin : rd_next
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (w_rd_accept) begin
            rd_ptr_d  = rd_ptr_q + c_PTR_ONE;
            rd_data_d = mem_q[w_rd_idx];
        end
    end

    // Pointer and read-data registers, all returned to zero by reset.
    always_ff @(posedge clk) begin : ptr_regs
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional checking
    // ------------------------------------------------------------------------
`ifdef ASYNC_FIFO_ASSERT_EN
    // A write request while full is dropped; report it outside the busy window.
    a_wr_while_full : assert property (
        @(posedge clk) disable iff (!rst_n || wr_rst_q)
        !(bus.wr_en && w_full)
    ) else $error("async_fifo: write requested while full, word dropped");

    // A read request while empty is dropped; report it outside the busy window.
    a_rd_while_empty : assert property (
        @(posedge clk) disable iff (!rst_n || rd_rst_q)
        !(bus.rd_en && w_empty)
    ) else $error("async_fifo: read requested while empty, request dropped");

    // Occupancy can never exceed the physical depth.
    a_count_bound : assert property (
        @(posedge clk) disable iff (!rst_n)
        (w_count <= c_DEPTH_CNT)
    ) else $error("async_fifo: occupancy exceeds depth");
`else
    // Dropped requests are silent in this build; the datapath is unchanged.
`endif

endmodule
`default_nettype wire

// File: tb/tb_async_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_async_fifo
//  Description : Scoreboard bench for async_fifo. Two instances: RESERVE=0 and
//                RESERVE=2. Stimulus pushes expected words; per-instance
//                monitors pop and compare whenever a read has been accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo;

    localparam int DW = 8;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    async_fifo_if #(.DATA_WIDTH(DW)) bus0 ();
    async_fifo_if #(.DATA_WIDTH(DW)) bus2 ();

    async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESERVE(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESERVE(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q2 [$];
    logic          pend0 = 1'b0;
    logic          pend2 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected_read(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got read data %0h expected no accepted read", name, act);
    endtask

    // Monitor for the RESERVE=0 instance: a read accepted at an edge is
    // compared at the following falling edge.
    always @(negedge clk) begin : mon0
        if (pend0) begin
            if (q0.size() == 0) unexpected_read("rd0_extra", 32'(bus0.rd_data));
            else                check("rd0_data", 32'(bus0.rd_data), 32'(q0.pop_front()));
        end
        pend0 <= rst_n && bus0.rd_en && !bus0.empty;
    end

    // Monitor for the RESERVE=2 instance.
    always @(negedge clk) begin : mon2
        if (pend2) begin
            if (q2.size() == 0) unexpected_read("rd2_extra", 32'(bus2.rd_data));
            else                check("rd2_data", 32'(bus2.rd_data), 32'(q2.pop_front()));
        end
        pend2 <= rst_n && bus2.rd_en && !bus2.empty;
    end

    // One clock of stimulus on instance 0; returns 1ns after the edge.
    task automatic cyc0(input logic we, input logic [DW-1:0] wd, input logic re);
        bus0.wr_en   = we;
        bus0.wr_data = wd;
        bus0.rd_en   = re;
        @(posedge clk); #1;
        bus0.wr_en   = 1'b0;
        bus0.rd_en   = 1'b0;
    endtask

    task automatic cyc2(input logic we, input logic [DW-1:0] wd, input logic re);
        bus2.wr_en   = we;
        bus2.wr_data = wd;
        bus2.rd_en   = re;
        @(posedge clk); #1;
        bus2.wr_en   = 1'b0;
        bus2.rd_en   = 1'b0;
    endtask

    // Watchdog: the run must never hang.
    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "tb_async_fifo watchdog expired");
    end

    initial begin : stim
        int  n_wr;
        bit  done;

        bus0.wr_en = 1'b0; bus0.wr_data = '0; bus0.rd_en = 1'b0;
        bus2.wr_en = 1'b0; bus2.wr_data = '0; bus2.rd_en = 1'b0;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_empty",    32'(bus0.empty),    1);
        check("rst_has_data", 32'(bus0.has_data), 0);
        check("rst_full",     32'(bus0.full),     1);
        check("rst_rd_data",  32'(bus0.rd_data),  0);
        check("rst_wr_rst",   32'(dut0.wr_rst),   1);
        check("rst_rd_rst",   32'(dut0.rd_rst),   1);
        check("rst2_full",    32'(bus2.full),     1);

        // Release; writes attempted during the busy window must be dropped.
        rst_n        = 1'b1;
        bus0.wr_en   = 1'b1;
        bus0.wr_data = 8'hC3;
        @(posedge clk); #1;
        check("busy1_full",   32'(bus0.full),   1);
        check("busy1_wr_rst", 32'(dut0.wr_rst), 1);
        @(posedge clk); #1;
        check("busy2_full",   32'(bus0.full),   1);
        check("busy2_empty",  32'(bus0.empty),  1);
        bus0.wr_en = 1'b0;
        @(posedge clk); #1;
        check("ready_full",   32'(bus0.full),   0);
        check("ready_wr_rst", 32'(dut0.wr_rst), 0);
        check("ready_rd_rst", 32'(dut0.rd_rst), 0);
        check("ready_empty",  32'(bus0.empty),  1);
        check("ready2_full",  32'(bus2.full),   0);

        // ---------------- fill to full, drop 17th, drain ----------------
        for (int i = 0; i < 16; i++) begin
            q0.push_back(8'(i));
            cyc0(1'b1, 8'(i), 1'b0);
            if (i == 0)  check("first_wr_empty", 32'(bus0.empty), 0);
            if (i == 14) check("fill15_full",    32'(bus0.full),  0);
        end
        check("fill16_full",     32'(bus0.full),     1);
        check("fill16_has_data", 32'(bus0.has_data), 1);
        cyc0(1'b1, 8'hAA, 1'b0);
        check("fill17_full",     32'(bus0.full),     1);
        for (int i = 0; i < 16; i++) begin
            cyc0(1'b0, 8'h00, 1'b1);
            if (i == 14) check("drain15_empty", 32'(bus0.empty), 0);
        end
        check("drain_empty",    32'(bus0.empty),    1);
        check("drain_has_data", 32'(bus0.has_data), 0);
        cyc0(1'b0, 8'h00, 1'b0);
        check("hold_rd_data",   32'(bus0.rd_data),  32'h0F);
        cyc0(1'b0, 8'h00, 1'b1);
        check("empty_rd_hold",  32'(bus0.rd_data),  32'h0F);
        check("empty_rd_empty", 32'(bus0.empty),    1);

        // ---------------- repeated fill/drain: pointer wrap ----------------
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) begin
                q0.push_back(8'(i));
                cyc0(1'b1, 8'(i), 1'b0);
            end
            check("cyc_full", 32'(bus0.full), 1);
            for (int i = 0; i < 16; i++) cyc0(1'b0, 8'h00, 1'b1);
            check("cyc_empty", 32'(bus0.empty), 1);
        end

        // ---------------- simultaneous read+write ----------------
        // On empty: write taken, read ignored.
        q0.push_back(8'h40);
        cyc0(1'b1, 8'h40, 1'b1);
        check("rw_empty_empty", 32'(bus0.empty), 0);
        // At count=1: both taken, count stays 1, order preserved.
        for (int k = 1; k <= 4; k++) begin
            q0.push_back(8'(8'h40 + k));
            cyc0(1'b1, 8'(8'h40 + k), 1'b1);
            check("rw_c1_empty", 32'(bus0.empty), 0);
            check("rw_c1_full",  32'(bus0.full),  0);
        end
        cyc0(1'b0, 8'h00, 1'b1);
        check("rw_c1_drained", 32'(bus0.empty), 1);
        // On full: read taken, write ignored.
        for (int i = 0; i < 16; i++) begin
            q0.push_back(8'(8'h80 + i));
            cyc0(1'b1, 8'(8'h80 + i), 1'b0);
        end
        cyc0(1'b1, 8'hFF, 1'b1);
        check("rw_full_full", 32'(bus0.full), 0);
        for (int i = 0; i < 15; i++) cyc0(1'b0, 8'h00, 1'b1);
        check("rw_full_drained", 32'(bus0.empty), 1);

        // ---------------- streaming 0..499 ----------------
        n_wr = 0;
        done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            bus0.wr_en   = (n_wr < 500) && !bus0.full;
            bus0.wr_data = 8'(n_wr);
            if (bus0.wr_en) begin
                q0.push_back(8'(n_wr));
                n_wr++;
            end
            bus0.rd_en = ((c % 3) == 0) && !bus0.empty;
            @(posedge clk); #1;
            if (n_wr == 500 && bus0.empty) done = 1'b1;
        end
        bus0.wr_en = 1'b0;
        bus0.rd_en = 1'b0;
        check("stream_done", 32'(done), 1);
        cyc0(1'b0, 8'h00, 1'b0);
        check("stream_sb_left", 32'(q0.size()), 0);
        check("stream_last",    32'(bus0.rd_data), 32'hF3);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 5; i++) cyc0(1'b1, 8'(8'h11 + i), 1'b0);
        check("mid_pre_empty", 32'(bus0.empty), 0);
        rst_n = 1'b0;
        cyc0(1'b0, 8'h00, 1'b0);
        check("mid_rst_empty",    32'(bus0.empty),    1);
        check("mid_rst_has_data", 32'(bus0.has_data), 0);
        check("mid_rst_full",     32'(bus0.full),     1);
        check("mid_rst_rd_data",  32'(bus0.rd_data),  0);
        rst_n = 1'b1;
        repeat (3) cyc0(1'b0, 8'h00, 1'b0);
        check("mid_post_full",  32'(bus0.full),  0);
        check("mid_post_empty", 32'(bus0.empty), 1);
        q0.push_back(8'h5A);
        cyc0(1'b1, 8'h5A, 1'b0);
        cyc0(1'b0, 8'h00, 1'b1);
        check("mid_one_empty", 32'(bus0.empty), 1);

        // ---------------- RESERVE=2 instance ----------------
        for (int i = 0; i < 14; i++) begin
            q2.push_back(8'(8'h20 + i));
            cyc2(1'b1, 8'(8'h20 + i), 1'b0);
            if (i == 12) check("res13_full", 32'(bus2.full), 0);
        end
        check("res14_full", 32'(bus2.full), 1);
        cyc2(1'b1, 8'hEE, 1'b0);
        check("res15_full", 32'(bus2.full), 1);
        for (int i = 0; i < 14; i++) cyc2(1'b0, 8'h00, 1'b1);
        check("res_drain_empty", 32'(bus2.empty), 1);
        cyc2(1'b0, 8'h00, 1'b1);
        check("res_empty_rd_hold", 32'(bus2.rd_data), 32'h2D);

        // ---------------- wrap-up ----------------
        cyc0(1'b0, 8'h00, 1'b0);
        cyc0(1'b0, 8'h00, 1'b0);
        check("sb0_left", 32'(q0.size()), 0);
        check("sb2_left", 32'(q2.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
